// File: rtl/noise_pkg.sv
// noise_pkg: shared constants and helpers for the APU noise channel.
//   PTABLE_NTSC / PTABLE_PAL : timer periods indexed by $400E[3:0]
//   LTABLE                   : 2A03 length-counter load values indexed by $400F[7:3]
//   Addr*                    : register offsets within the $400C-$400F window
//   f_* functions            : field extraction from register write data
package noise_pkg;

  localparam logic [1:0] AddrCtrl   = 2'd0;  // $400C
  localparam logic [1:0] AddrUnused = 2'd1;  // $400D, no function on this channel
  localparam logic [1:0] AddrPeriod = 2'd2;  // $400E
  localparam logic [1:0] AddrLength = 2'd3;  // $400F

  localparam logic [11:0] PTABLE_NTSC [16] = '{
    12'd4,   12'd8,   12'd16,  12'd32,  12'd64,  12'd96,   12'd128,  12'd160,
    12'd202, 12'd254, 12'd380, 12'd508, 12'd762, 12'd1016, 12'd2034, 12'd4068
  };

  localparam logic [11:0] PTABLE_PAL [16] = '{
    12'd4,   12'd8,   12'd14,  12'd30,  12'd60,  12'd88,  12'd118,  12'd148,
    12'd188, 12'd236, 12'd354, 12'd472, 12'd708, 12'd944, 12'd1890, 12'd3778
  };

  localparam logic [7:0] LTABLE [32] = '{
    8'd10,  8'd254, 8'd20, 8'd2,  8'd40, 8'd4,  8'd80, 8'd6,
    8'd160, 8'd8,   8'd60, 8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
    8'd12,  8'd16,  8'd24, 8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
    8'd192, 8'd24,  8'd72, 8'd26, 8'd16, 8'd28, 8'd32, 8'd30
  };

  function automatic logic f_halt_loop(input logic [7:0] d);
    return d[5];
  endfunction

  function automatic logic f_const_vol(input logic [7:0] d);
    return d[4];
  endfunction

  function automatic logic [3:0] f_vol_n(input logic [7:0] d);
    return d[3:0];
  endfunction

  function automatic logic f_mode(input logic [7:0] d);
    return d[7];
  endfunction

  function automatic logic [3:0] f_period_idx(input logic [7:0] d);
    return d[3:0];
  endfunction

  function automatic logic [4:0] f_len_idx(input logic [7:0] d);
    return d[7:3];
  endfunction

  function automatic logic [11:0] period_lookup(input logic pal, input logic [3:0] idx);
    return pal ? PTABLE_PAL[idx] : PTABLE_NTSC[idx];
  endfunction

  // Largest period in the selected table; sizes the timer check at elaboration.
  function automatic int unsigned ptable_max(input logic pal);
    int unsigned m;
    m = 0;
    for (int i = 0; i < 16; i++) begin
      if (int'(period_lookup(pal, 4'(i))) > int'(m)) m = int'(period_lookup(pal, 4'(i)));
    end
    return m;
  endfunction

endpackage

// File: rtl/noise_envelope.sv
// noise_envelope: APU envelope generator (shared with the pulse channels).
//   clk, rst   : clock, synchronous active-high reset
//   qframe     : quarter-frame strobe, clocks the divider/decay counter
//   start      : restart request; seen on qframe, reloads decay to 15
//   loop       : wrap decay from 0 back to 15
//   const_vol  : output n directly instead of the decay level
//   n          : divider reload / constant volume
//   vol[3:0]   : current volume
module noise_envelope (
  input  logic       clk,
  input  logic       rst,
  input  logic       qframe,
  input  logic       start,
  input  logic       loop,
  input  logic       const_vol,
  input  logic [3:0] n,
  output logic [3:0] vol
);

  logic [3:0] decay_q, decay_d;
  logic [3:0] div_q, div_d;

  always_comb begin
    decay_d = decay_q;
    div_d   = div_q;
    if (qframe) begin
      if (start) begin
        decay_d = 4'd15;
        div_d   = n;
      end else if (div_q == 4'd0) begin
        div_d = n;
        if (decay_q != 4'd0) begin
          decay_d = decay_q - 4'd1;
        end else if (loop) begin
          decay_d = 4'd15;
        end
      end else begin
        div_d = div_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      decay_q <= 4'd0;
      div_q   <= 4'd0;
    end else begin
      decay_q <= decay_d;
      div_q   <= div_d;
    end
  end

  assign vol = const_vol ? n : decay_q;

endmodule

// File: rtl/noise_channel.sv
// noise_channel: APU noise channel (timer, LFSR, length counter, envelope).
//   clk, rst   : clock, synchronous active-high reset
//   tick       : APU timer enable
//   qframe     : quarter-frame strobe (envelope)
//   hframe     : half-frame strobe (length counter)
//   wr_en      : register write strobe
//   wr_addr    : 0=$400C 1=$400D(ignored) 2=$400E 3=$400F
//   wr_data    : write data
//   len_en     : status-register channel enable; 0 holds length at 0
//   sample     : registered 4-bit output to the mixer
//   len_active : registered, length counter non-zero
module noise_channel
  import noise_pkg::*;
#(
  parameter int unsigned LFSR_W    = 15,
  parameter int unsigned SHORT_TAP = 6,
  parameter int unsigned TIMER_W   = 12,
  parameter int unsigned PAL       = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       qframe,
  input  logic       hframe,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       len_en,
  output logic [3:0] sample,
  output logic       len_active
);

  localparam logic        PalSel      = (PAL != 0);
  localparam int unsigned PeriodMaxM1 = ptable_max(PalSel) - 1;

  if (TIMER_W < $clog2(PeriodMaxM1 + 1)) begin : g_timer_w_err
    $error("TIMER_W too narrow for the selected period table");
  end

  logic               loop_q, loop_d;
  logic               const_q, const_d;
  logic [3:0]         n_q, n_d;
  logic               mode_q, mode_d;
  logic [3:0]         pi_q, pi_d;
  logic               env_start_q, env_start_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [7:0]         length_q, length_d;
  logic [3:0]         sample_q, sample_d;
  logic               len_active_q, len_active_d;
  logic               lfsr_fb;
  logic [3:0]         env_vol;

  assign lfsr_fb = lfsr_q[0] ^ (mode_q ? lfsr_q[SHORT_TAP] : lfsr_q[1]);

  noise_envelope u_envelope (
    .clk       (clk),
    .rst       (rst),
    .qframe    (qframe),
    .start     (env_start_q),
    .loop      (loop_q),
    .const_vol (const_q),
    .n         (n_q),
    .vol       (env_vol)
  );

  always_comb begin
    loop_d      = loop_q;
    const_d     = const_q;
    n_d         = n_q;
    mode_d      = mode_q;
    pi_d        = pi_q;
    env_start_d = env_start_q;
    timer_d     = timer_q;
    lfsr_d      = lfsr_q;
    length_d    = length_q;

    // New period only applies at the next reload, so $400E never touches timer_q.
    if (tick) begin
      if (timer_q == '0) begin
        timer_d = TIMER_W'(period_lookup(PalSel, pi_q) - 12'd1);
        lfsr_d  = {lfsr_fb, lfsr_q[LFSR_W-1:1]};
      end else begin
        timer_d = timer_q - TIMER_W'(1);
      end
    end

    if (hframe && (length_q != 8'd0) && !loop_q) begin
      length_d = length_q - 8'd1;
    end

    // The envelope consumes the pre-write start flag; a coincident $400F write re-arms it below.
    if (qframe) begin
      env_start_d = 1'b0;
    end

    if (wr_en) begin
      case (wr_addr)
        AddrCtrl: begin
          loop_d  = f_halt_loop(wr_data);
          const_d = f_const_vol(wr_data);
          n_d     = f_vol_n(wr_data);
        end
        AddrPeriod: begin
          mode_d = f_mode(wr_data);
          pi_d   = f_period_idx(wr_data);
        end
        AddrLength: begin
          env_start_d = 1'b1;
          if (len_en) begin
            length_d = LTABLE[f_len_idx(wr_data)];
          end
        end
        default: ;
      endcase
    end

    if (!len_en) begin
      length_d = 8'd0;
    end

    sample_d     = (lfsr_q[0] || (length_q == 8'd0)) ? 4'd0 : env_vol;
    len_active_d = (length_q != 8'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      loop_q       <= 1'b0;
      const_q      <= 1'b0;
      n_q          <= 4'd0;
      mode_q       <= 1'b0;
      pi_q         <= 4'd0;
      env_start_q  <= 1'b0;
      timer_q      <= '0;
      lfsr_q       <= LFSR_W'(1);
      length_q     <= 8'd0;
      sample_q     <= 4'd0;
      len_active_q <= 1'b0;
    end else begin
      loop_q       <= loop_d;
      const_q      <= const_d;
      n_q          <= n_d;
      mode_q       <= mode_d;
      pi_q         <= pi_d;
      env_start_q  <= env_start_d;
      timer_q      <= timer_d;
      lfsr_q       <= lfsr_d;
      length_q     <= length_d;
      sample_q     <= sample_d;
      len_active_q <= len_active_d;
    end
  end

  assign sample     = sample_q;
  assign len_active = len_active_q;

endmodule

// File: tb/tb_noise_channel.sv
// tb_noise_channel: directed and randomized stimulus for noise_channel, checked every cycle
// against a behavioural model of the channel kept in plain integers.
module tb_noise_channel;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       qframe;
  logic       hframe;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       len_en;
  logic [3:0] sample;
  logic       len_active;

  noise_channel dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .qframe     (qframe),
    .hframe     (hframe),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .len_en     (len_en),
    .sample     (sample),
    .len_active (len_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int PT [16] = '{4, 8, 16, 32, 64, 96, 128, 160, 202, 254, 380, 508, 762, 1016,
                             2034, 4068};
  localparam int LT [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                             12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};

  int m_lfsr, m_timer, m_len, m_decay, m_div, m_n, m_pi;
  bit m_loop, m_const, m_mode, m_estart;
  int exp_sample;
  int exp_act;

  function automatic int lfsr_next(input int v, input bit short_mode);
    int fb;
    fb = (v ^ (v >> (short_mode ? 6 : 1))) & 1;
    return (v >> 1) | (fb << 14);
  endfunction

  function automatic int lfsr_period(input bit short_mode);
    int v;
    v = lfsr_next(1, short_mode);
    for (int i = 1; i < 40000; i++) begin
      if (v == 1) return i;
      v = lfsr_next(v, short_mode);
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_lfsr = 1; m_timer = 0; m_len = 0; m_decay = 0; m_div = 0; m_n = 0; m_pi = 0;
      m_loop = 0; m_const = 0; m_mode = 0; m_estart = 0;
      exp_sample = 0; exp_act = 0;
    end else begin
      // outputs show the state as it stood before this edge
      exp_sample = ((m_lfsr % 2) == 1 || m_len == 0) ? 0 : (m_const ? m_n : m_decay);
      exp_act    = (m_len != 0) ? 1 : 0;
      if (tick) begin
        if (m_timer == 0) begin
          m_timer = PT[m_pi] - 1;
          m_lfsr  = lfsr_next(m_lfsr, m_mode);
        end else begin
          m_timer = m_timer - 1;
        end
      end
      if (hframe && m_len != 0 && !m_loop) m_len = m_len - 1;
      if (wr_en && wr_addr == 2'd3 && len_en) m_len = LT[wr_data[7:3]];
      if (!len_en) m_len = 0;
      if (qframe) begin
        if (m_estart) begin
          m_estart = 0; m_decay = 15; m_div = m_n;
        end else if (m_div == 0) begin
          m_div = m_n;
          if (m_decay != 0) m_decay = m_decay - 1;
          else if (m_loop) m_decay = 15;
        end else begin
          m_div = m_div - 1;
        end
      end
      if (wr_en && wr_addr == 2'd3) m_estart = 1;
      if (wr_en && wr_addr == 2'd0) begin
        m_loop = wr_data[5]; m_const = wr_data[4]; m_n = int'(wr_data[3:0]);
      end
      if (wr_en && wr_addr == 2'd2) begin
        m_mode = wr_data[7]; m_pi = int'(wr_data[3:0]);
      end
    end
  end

  // per-cycle compare, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("sample", 32'(sample), 32'(exp_sample));
      check("len_active", 32'(len_active), 32'(exp_act));
    end
  end

  // ---------------- stimulus ----------------
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  bit found;
  logic [7:0] rd;

  initial begin
    rst = 1'b1; tick = 1'b0; qframe = 1'b0; hframe = 1'b0;
    wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'd0; len_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_sample", 32'(sample), 32'd0);
    check("reset_len_active", 32'(len_active), 32'd0);
    check("model_long_period", 32'(lfsr_period(1'b0)), 32'd32767);
    check("model_short_period", 32'(lfsr_period(1'b1)), 32'd93);

    // LFSR stepping: pi=0, tick every cycle -> steps on ticks 1, 5, 9, ...
    rst = 1'b0; tick = 1'b1;
    @(negedge clk);
    check("model_lfsr_step1", 32'(m_lfsr), 32'h4000);
    repeat (4) @(negedge clk);
    check("model_lfsr_step2", 32'(m_lfsr), 32'h2000);

    // length load with constant volume 15
    len_en = 1'b1;
    wr(2'd0, 8'h1F);
    wr(2'd2, 8'h00);
    wr(2'd3, 8'h08);
    @(negedge clk);
    check("len_load_active", 32'(len_active), 32'd1);
    check("model_len_load", 32'(m_len), 32'd254);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (sample != 4'd0) found = 1'b1;
    end
    check("const_vol_sample", found ? 32'(sample) : 32'd0, 32'd15);

    // short mode runs across several full periods
    wr(2'd2, 8'h80);
    repeat (400) @(negedge clk);

    // length countdown over 254 half-frames
    hframe = 1'b1;
    repeat (253) @(negedge clk);
    check("len_before_expire", 32'(len_active), 32'd1);
    @(negedge clk);
    hframe = 1'b0;
    @(negedge clk);
    check("len_expired", 32'(len_active), 32'd0);
    check("len_expired_sample", 32'(sample), 32'd0);

    // halt keeps the length
    wr(2'd0, 8'h3F);
    wr(2'd3, 8'h08);
    hframe = 1'b1;
    repeat (30) @(negedge clk);
    hframe = 1'b0;
    check("model_len_halt", 32'(m_len), 32'd254);
    check("len_halt_active", 32'(len_active), 32'd1);

    // len_en=0 blocks the load but still arms the envelope
    len_en = 1'b0;
    @(negedge clk);
    wr(2'd3, 8'h08);
    repeat (3) @(negedge clk);
    check("len_en0_active", 32'(len_active), 32'd0);
    check("model_len_en0_estart", 32'(m_estart), 32'd1);

    // $400F write coinciding with hframe loads LTABLE[3]=2 undecremented
    len_en = 1'b1;
    wr(2'd0, 8'h1F);
    hframe = 1'b1;
    wr(2'd3, 8'h18);
    hframe = 1'b0;
    check("model_len_collide", 32'(m_len), 32'd2);
    @(negedge clk);
    hframe = 1'b1;
    @(negedge clk);
    hframe = 1'b0;
    @(negedge clk);
    check("len_collide_one_left", 32'(len_active), 32'd1);
    hframe = 1'b1;
    @(negedge clk);
    hframe = 1'b0;
    @(negedge clk);
    check("len_collide_expired", 32'(len_active), 32'd0);

    // envelope decay with n=5
    wr(2'd0, 8'h05);
    wr(2'd3, 8'h08);
    qframe = 1'b1;
    @(negedge clk);
    qframe = 1'b0;
    check("model_env_start", 32'(m_decay), 32'd15);
    qframe = 1'b1;
    repeat (6) @(negedge clk);
    check("model_env_first_dec", 32'(m_decay), 32'd14);
    repeat (84) @(negedge clk);
    check("model_env_zero", 32'(m_decay), 32'd0);
    repeat (20) @(negedge clk);
    check("model_env_hold", 32'(m_decay), 32'd0);
    wr(2'd0, 8'h25);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (m_decay == 15) found = 1'b1;
    end
    check("model_env_loop_wrap", 32'(found), 32'd1);
    repeat (150) @(negedge clk);

    // reset mid-operation with every strobe and a $400F write asserted
    tick = 1'b1; qframe = 1'b1; hframe = 1'b1;
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'h08; rst = 1'b1;
    @(negedge clk);
    check("midrst_sample", 32'(sample), 32'd0);
    check("midrst_len_active", 32'(len_active), 32'd0);
    rst = 1'b0; wr_en = 1'b0; tick = 1'b0; qframe = 1'b0; hframe = 1'b0;
    check("model_midrst_lfsr", 32'(m_lfsr), 32'd1);
    repeat (2) @(negedge clk);
    check("midrst_write_ignored", 32'(len_active), 32'd0);

    // randomized traffic
    len_en = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      tick   = ($urandom_range(0, 1) == 0);
      qframe = ($urandom_range(0, 7) == 0);
      hframe = ($urandom_range(0, 63) == 0);
      rst    = ($urandom_range(0, 999) == 0);
      if (len_en && $urandom_range(0, 299) == 0) len_en = 1'b0;
      else if (!len_en && $urandom_range(0, 9) == 0) len_en = 1'b1;
      wr_en   = ($urandom_range(0, 15) == 0);
      wr_addr = 2'($urandom_range(0, 3));
      rd      = 8'($urandom);
      if (wr_addr == 2'd2) rd[3:0] = 4'($urandom_range(0, 3));
      wr_data = rd;
      @(negedge clk);
    end
    rst = 1'b0; wr_en = 1'b0; tick = 1'b0; qframe = 1'b0; hframe = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
